// File: rtl/ext_int_ctrl_pkg.sv
// Shared definitions for the external interrupt controller: register map,
// per-source configuration record and the mcause code helper.
package ExtIntCtrl_Pkg;

  localparam int ID_W       = 5;
  localparam int CODE_W     = 27;
  localparam int PRIO_W_MAX = 8;

  localparam logic [5:0] ADDR_PENDING   = 6'h00;
  localparam logic [5:0] ADDR_ENABLE    = 6'h01;
  localparam logic [5:0] ADDR_TRIGGER   = 6'h02;
  localparam logic [5:0] ADDR_THRESHOLD = 6'h03;
  localparam logic [5:0] ADDR_CLAIM     = 6'h04;
  localparam logic [5:0] ADDR_PRIO_BASE = 6'h08;

  // prio is stored zero-extended to PRIO_W_MAX so the record is parameter-free.
  typedef struct packed {
    logic [PRIO_W_MAX-1:0] prio;
    logic                  enable;
    logic                  trigger;
  } src_cfg_t;

  function automatic logic [CODE_W-1:0] IdToCode(input logic [ID_W-1:0] id);
    return {{(CODE_W - ID_W){1'b0}}, id};
  endfunction

endpackage

// File: rtl/ext_int_gateway.sv
// Per-source interrupt gateway: input synchronizer, edge detect and the
// pending / in_service flops driven by the claim/complete handshake.
module ext_int_gateway #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_sync,
  input  logic irq_raw,
  input  logic trigger,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic in_service
);

  logic lvl;
  logic prev_lvl;
  logic rise;
  logic pending_d;
  logic in_service_d;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign lvl = irq_raw;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
      if (rst_sync) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= irq_raw;
        for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end

    assign lvl = sync_q[SYNC_STAGES-1];
  end

  assign rise = lvl & ~prev_lvl;

  // Edge mode lets a fresh edge override a same-cycle claim so it is never lost;
  // level mode simply tracks the line whenever the source is not being serviced.
  always_comb begin
    in_service_d = (in_service & ~complete) | claim;
    if (trigger) pending_d = (rise & ~in_service) | (pending & ~claim);
    else         pending_d = lvl & ~in_service_d;
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      prev_lvl   <= 1'b0;
      pending    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      prev_lvl   <= lvl;
      pending    <= pending_d;
      in_service <= in_service_d;
    end
  end

endmodule

// File: rtl/ext_int_ctrl.sv
// Machine-mode external interrupt controller: per-source gateways, priority
// arbiter with threshold, register port with claim/complete, registered meip.
module ext_int_ctrl
  import ExtIntCtrl_Pkg::*;
#(
  parameter int NUM_SRC     = 16,
  parameter int PRIO_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_sync,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               reg_we,
  input  logic               reg_re,
  input  logic [5:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               meip,
  output logic [26:0]        custom_int_code
);

  src_cfg_t              cfg [NUM_SRC];
  logic [PRIO_W-1:0]     threshold;
  logic [NUM_SRC-1:0]    pending;
  logic [NUM_SRC-1:0]    in_service;
  logic [NUM_SRC-1:0]    claim;
  logic [NUM_SRC-1:0]    complete;
  logic [ID_W-1:0]       win_id;
  logic [PRIO_W_MAX-1:0] win_prio;
  logic                  sel_claim;
  logic                  wr_claim;
  logic [31:0]           rd_mux;
  logic                  unused_wdata;

  assign sel_claim    = reg_re && (reg_addr == ADDR_CLAIM);
  assign wr_claim     = reg_we && (reg_addr == ADDR_CLAIM);
  assign unused_wdata = ^reg_wdata;

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      threshold <= '0;
      for (int i = 0; i < NUM_SRC; i++) cfg[i] <= '0;
    end else if (reg_we) begin
      if (reg_addr == ADDR_ENABLE)
        for (int i = 0; i < NUM_SRC; i++) cfg[i].enable <= reg_wdata[i];
      if (reg_addr == ADDR_TRIGGER)
        for (int i = 0; i < NUM_SRC; i++) cfg[i].trigger <= reg_wdata[i];
      if (reg_addr == ADDR_THRESHOLD)
        threshold <= reg_wdata[PRIO_W-1:0];
      for (int i = 0; i < NUM_SRC; i++)
        if (reg_addr == ADDR_PRIO_BASE + 6'(i))
          cfg[i].prio <= PRIO_W_MAX'(reg_wdata[PRIO_W-1:0]);
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign claim[i]    = sel_claim && (win_id == ID_W'(i + 1));
    assign complete[i] = wr_claim && (reg_wdata[ID_W-1:0] == ID_W'(i + 1));

    ext_int_gateway #(.SYNC_STAGES(SYNC_STAGES)) u_gw (
      .clk        (clk),
      .rst_sync   (rst_sync),
      .irq_raw    (irq_src[i]),
      .trigger    (cfg[i].trigger),
      .claim      (claim[i]),
      .complete   (complete[i]),
      .pending    (pending[i]),
      .in_service (in_service[i])
    );
  end

  // Ascending scan with a strict compare keeps the lowest ID on priority ties.
  always_comb begin
    win_id   = '0;
    win_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending[i] && cfg[i].enable && (cfg[i].prio > PRIO_W_MAX'(threshold)) &&
          (cfg[i].prio > win_prio)) begin
        win_id   = ID_W'(i + 1);
        win_prio = cfg[i].prio;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      ADDR_PENDING:   rd_mux = 32'(pending);
      ADDR_ENABLE:    for (int i = 0; i < NUM_SRC; i++) rd_mux[i] = cfg[i].enable;
      ADDR_TRIGGER:   for (int i = 0; i < NUM_SRC; i++) rd_mux[i] = cfg[i].trigger;
      ADDR_THRESHOLD: rd_mux = 32'(threshold);
      ADDR_CLAIM:     rd_mux = 32'(win_id);
      default: begin
        for (int i = 0; i < NUM_SRC; i++)
          if (reg_addr == ADDR_PRIO_BASE + 6'(i)) rd_mux = 32'(cfg[i].prio);
      end
    endcase
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst_sync) begin
      meip            <= 1'b0;
      custom_int_code <= '0;
      reg_rdata       <= '0;
    end else begin
      meip            <= (win_id != '0);
      custom_int_code <= IdToCode(win_id);
      if (reg_re) reg_rdata <= rd_mux;
    end
  end

endmodule
